lock_access_controller: RTL and testbench

//  Sequences the bit-serial digital door-lock FSM from a parallel keypad code.
//  - Accepts a CODE_LEN-bit code over a valid/ready handshake.
//  - Resets the lock FSM, then shifts the code in MSB first.
//  - Judges the attempt and keeps the attempt-failure count.
//  - Enforces a lockout after MAX_FAILS consecutive failures.
//  - Relocks on command or on timeout.

---
 rtl/lock_pkg.sv | 26 ++
 rtl/lock_cycle_timer.sv | 36 +++
 rtl/lock_access_controller.sv | 166 ++++++++++++++++
 tb/tb_lock_access_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// ============================================================================
// lock_pkg: shared state encoding and default sizing for the lock controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lock_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_OPEN    = 3'd4;
  localparam logic [2:0] ST_RELOCK  = 3'd5;
  localparam logic [2:0] ST_LOCKOUT = 3'd6;

  localparam int c_code_len       = 4;
  localparam int c_max_fails      = 3;
  localparam int c_fail_w         = 2;
  localparam int c_lockout_cycles = 1000;
  localparam int c_relock_cycles  = 500;
  localparam int c_tmr_w          = 16;

endpackage

`default_nettype wire

// File: rtl/lock_cycle_timer.sv
// ============================================================================
// lock_cycle_timer: loadable down-counter; expired is high while the count is 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lock_cycle_timer
  import lock_pkg::*;
#(
  parameter int TMR_W = c_tmr_w
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/lock_access_controller.sv
// ============================================================================
// lock_access_controller: feeds a keypad code bit-serially into the lock FSM,
// judges the attempt, counts failures, and handles lockout and relock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lock_access_controller
  import lock_pkg::*;
#(
  parameter int CODE_LEN       = c_code_len,
  parameter int MAX_FAILS      = c_max_fails,
  parameter int FAIL_W         = c_fail_w,
  parameter int LOCKOUT_CYCLES = c_lockout_cycles,
  parameter int RELOCK_CYCLES  = c_relock_cycles,
  parameter int TMR_W          = c_tmr_w
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                code_valid,
  input  logic [CODE_LEN-1:0] code_bits,
  output logic                code_ready,
  input  logic                lock_cmd,
  input  logic                lock_locked,
  input  logic                lock_unlocked,
  output logic                lock_rst,
  output logic                lock_data_in,
  output logic                lock_submit,
  output logic                door_open,
  output logic                lockout,
  output logic [FAIL_W-1:0]   fail_cnt,
  output logic                attempt_ok,
  output logic                attempt_fail
);

  localparam int                c_idx_w     = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0]  c_fail_max = FAIL_W'(MAX_FAILS);
  localparam logic [FAIL_W-1:0]  c_fail_sat = {FAIL_W{1'b1}};

  logic [2:0]          r_state;
  logic [CODE_LEN-1:0] r_code;
  logic [c_idx_w-1:0]  r_idx;

  logic                w_success;
  logic [FAIL_W-1:0]   w_fail_next;
  logic                w_to_lockout;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_load_val;
  logic                w_tmr_en;
  logic                w_tmr_expired;

  // Only unlocked=1 with locked=0 counts as success; the illegal 1/1 is a failure.
  assign w_success      = lock_unlocked && !lock_locked;
  assign w_fail_next    = (fail_cnt == c_fail_sat) ? fail_cnt : fail_cnt + 1'b1;
  assign w_to_lockout   = !w_success && (w_fail_next == c_fail_max);
  assign w_tmr_load     = (r_state == ST_CHECK) && (w_success || w_to_lockout);
  assign w_tmr_load_val = w_success ? TMR_W'(RELOCK_CYCLES) : TMR_W'(LOCKOUT_CYCLES);
  assign w_tmr_en       = (r_state == ST_OPEN) || (r_state == ST_LOCKOUT);

  lock_cycle_timer #(
    .TMR_W(TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (w_tmr_load),
    .load_val(w_tmr_load_val),
    .en      (w_tmr_en),
    .expired (w_tmr_expired)
  );

  // Outputs are registered alongside the next state so they always decode r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_code       <= '0;
      r_idx        <= '0;
      fail_cnt     <= '0;
      code_ready   <= 1'b1;
      lock_rst     <= 1'b0;
      lock_data_in <= 1'b0;
      lock_submit  <= 1'b0;
      door_open    <= 1'b0;
      lockout      <= 1'b0;
      attempt_ok   <= 1'b0;
      attempt_fail <= 1'b0;
    end else begin
      lock_rst     <= 1'b0;
      lock_data_in <= 1'b0;
      lock_submit  <= 1'b0;
      attempt_ok   <= 1'b0;
      attempt_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (code_valid && code_ready) begin
            r_code     <= code_bits;
            r_idx      <= '0;
            code_ready <= 1'b0;
            lock_rst   <= 1'b1;
            r_state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          lock_data_in <= r_code[CODE_LEN-1];
          r_code       <= r_code << 1;
          r_state      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_idx == c_last_idx) begin
            r_state <= ST_CHECK;
          end else begin
            lock_data_in <= r_code[CODE_LEN-1];
            r_code       <= r_code << 1;
            r_idx        <= r_idx + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_success) begin
            attempt_ok <= 1'b1;
            fail_cnt   <= '0;
            door_open  <= 1'b1;
            r_state    <= ST_OPEN;
          end else begin
            attempt_fail <= 1'b1;
            fail_cnt     <= w_fail_next;
            if (w_to_lockout) begin
              lockout <= 1'b1;
              r_state <= ST_LOCKOUT;
            end else begin
              code_ready <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
        end
        ST_OPEN: begin
          if (lock_cmd || w_tmr_expired) begin
            door_open   <= 1'b0;
            lock_submit <= 1'b1;
            r_state     <= ST_RELOCK;
          end
        end
        ST_RELOCK: begin
          code_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
        ST_LOCKOUT: begin
          if (w_tmr_expired) begin
            fail_cnt   <= '0;
            lockout    <= 1'b0;
            code_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          door_open  <= 1'b0;
          lockout    <= 1'b0;
          code_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lock_access_controller.sv
// ============================================================================
// tb_lock_access_controller: randomized attempts against a transaction-level
// reference model and a behavioural bit-serial lock.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lock_access_controller;

  localparam int CL = 4;
  localparam int MF = 3;
  localparam int FW = 2;
  localparam int LC = 40;
  localparam int RC = 25;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          code_valid;
  logic [CL-1:0] code_bits;
  logic          code_ready;
  logic          lock_cmd;
  logic          lock_locked;
  logic          lock_unlocked;
  logic          lock_rst;
  logic          lock_data_in;
  logic          lock_submit;
  logic          door_open;
  logic          lockout;
  logic [FW-1:0] fail_cnt;
  logic          attempt_ok;
  logic          attempt_fail;

  logic          mdl_locked;
  logic          mdl_unlocked;
  logic          mdl_err;
  int            mdl_pos;
  logic          ovr_en;
  logic          ovr_l;
  logic          ovr_u;
  logic [CL-1:0] secret;

  int checks = 0;
  int errors = 0;
  int exp_fail = 0;

  assign lock_locked   = ovr_en ? ovr_l : mdl_locked;
  assign lock_unlocked = ovr_en ? ovr_u : mdl_unlocked;

  always #5 clk = ~clk;

  lock_access_controller #(
    .CODE_LEN(CL), .MAX_FAILS(MF), .FAIL_W(FW),
    .LOCKOUT_CYCLES(LC), .RELOCK_CYCLES(RC), .TMR_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_bits(code_bits),
    .code_ready(code_ready), .lock_cmd(lock_cmd), .lock_locked(lock_locked),
    .lock_unlocked(lock_unlocked), .lock_rst(lock_rst), .lock_data_in(lock_data_in),
    .lock_submit(lock_submit), .door_open(door_open), .lockout(lockout),
    .fail_cnt(fail_cnt), .attempt_ok(attempt_ok), .attempt_fail(attempt_fail)
  );

  // Bit-serial lock: one code bit per clock after its reset, any wrong bit parks it in error.
  always @(posedge clk or posedge reset) begin
    if (reset || lock_rst) begin
      mdl_pos <= 0; mdl_err <= 1'b0; mdl_locked <= 1'b1; mdl_unlocked <= 1'b0;
    end else if (lock_submit) begin
      mdl_pos <= 0; mdl_err <= 1'b1; mdl_locked <= 1'b1; mdl_unlocked <= 1'b0;
    end else if (!mdl_unlocked && !mdl_err) begin
      if (lock_data_in == secret[CL-1-mdl_pos]) begin
        if (mdl_pos == CL-1) begin
          mdl_unlocked <= 1'b1; mdl_locked <= 1'b0;
        end
        mdl_pos <= mdl_pos + 1;
      end else begin
        mdl_err <= 1'b1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] out_vec();
    return {22'd0, code_ready, lock_rst, lock_data_in, lock_submit, door_open,
            lockout, attempt_ok, attempt_fail, fail_cnt};
  endfunction

  // One full attempt; cmd_k is the open-cycle index carrying lock_cmd, -1 for none.
  task automatic attempt(input logic [CL-1:0] code, input bit ovr, input logic [1:0] lu,
                         input int cmd_k);
    int  n;
    bit  success;
    bit  bad;
    n = 0;
    while (!code_ready && n < 2000) begin tick(); n++; end
    check_eq("ready_wait", code_ready, 1);
    code_valid = 1'b1; code_bits = code;
    tick();
    code_valid = 1'b0;
    check_eq("arm_rst", lock_rst, 1);
    check_eq("arm_ready", code_ready, 0);
    for (int j = 0; j < CL; j++) begin
      code_valid = 1'($urandom); code_bits = CL'($urandom); lock_cmd = 1'($urandom);
      tick();
      check_eq("shift_bit", lock_data_in, code[CL-1-j]);
      check_eq("shift_rst", lock_rst, 0);
    end
    code_valid = 1'b0; lock_cmd = 1'b0;
    if (ovr) begin ovr_en = 1'b1; ovr_l = lu[1]; ovr_u = lu[0]; end
    tick();
    check_eq("check_quiet", {attempt_ok, attempt_fail, lock_data_in, door_open}, 0);
    success = ovr ? (lu == 2'b01) : (code == secret);
    tick();
    ovr_en = 1'b0;
    if (success) exp_fail = 0;
    else if (exp_fail < (1 << FW) - 1) exp_fail++;
    check_eq("attempt_ok", attempt_ok, success);
    check_eq("attempt_fail", attempt_fail, !success);
    check_eq("fail_cnt", fail_cnt, exp_fail);
    if (success) begin
      n = 0;
      while (door_open && n < RC + 10) begin
        lock_cmd = (n == cmd_k);
        tick();
        n++;
      end
      lock_cmd = 1'b0;
      check_eq("open_len", n, (cmd_k >= 0 && cmd_k <= RC) ? cmd_k + 1 : RC + 1);
      check_eq("relock_submit", lock_submit, 1);
      tick();
      check_eq("relock_done", {lock_submit, door_open, code_ready}, 3'b001);
    end else if (exp_fail == MF) begin
      check_eq("lockout_on", {lockout, code_ready}, 2'b10);
      n = 0; bad = 1'b0;
      while (lockout && n < LC + 10) begin
        if (code_ready) bad = 1'b1;
        code_valid = (n < 3); lock_cmd = 1'($urandom);
        tick();
        n++;
      end
      code_valid = 1'b0; lock_cmd = 1'b0;
      check_eq("lockout_len", n, LC + 1);
      check_eq("lockout_ready_low", bad, 0);
      exp_fail = 0;
      check_eq("lockout_exit", {code_ready, 30'(fail_cnt)}, {1'b1, 30'(exp_fail)});
      tick();
      check_eq("lockout_no_queue", lock_rst, 0);
    end else begin
      check_eq("fail_idle", {code_ready, lockout, door_open}, 3'b100);
    end
  endtask

  initial begin
    secret = 4'b1011;
    reset = 1'b1; code_valid = 1'b0; code_bits = '0; lock_cmd = 1'b0;
    ovr_en = 1'b0; ovr_l = 1'b0; ovr_u = 1'b0;
    repeat (3) tick();
    check_eq("reset_vals", out_vec(), 32'h200);
    reset = 1'b0;
    tick();
    check_eq("post_reset", out_vec(), 32'h200);

    attempt(4'b1011, 1'b0, 2'b00, -1);
    repeat (3) attempt(4'b0000, 1'b0, 2'b00, -1);
    attempt(4'b1011, 1'b0, 2'b00, RC);
    attempt(4'b0000, 1'b0, 2'b00, -1);
    attempt(4'b0101, 1'b0, 2'b00, -1);
    attempt(4'b1011, 1'b0, 2'b00, 3);
    attempt(4'b1011, 1'b1, 2'b11, -1);
    attempt(4'b1011, 1'b1, 2'b01, 0);

    // Abort an attempt with reset while bits are still shifting.
    attempt(4'b0110, 1'b0, 2'b00, -1);
    code_valid = 1'b1; code_bits = 4'b1011;
    tick();
    code_valid = 1'b0;
    tick(); tick();
    #1 reset = 1'b1;
    #1 check_eq("reset_async", out_vec(), 32'h200);
    tick();
    check_eq("reset_mid_shift", out_vec(), 32'h200);
    reset = 1'b0;
    exp_fail = 0;
    tick();
    check_eq("reset_recover", {code_ready, lock_rst, attempt_ok, attempt_fail}, 4'b1000);

    for (int i = 0; i < 40; i++) begin
      logic [CL-1:0] c;
      int            k;
      c = ($urandom_range(0, 1) == 1) ? secret : CL'($urandom);
      k = $urandom_range(0, RC + 5);
      if (k > RC + 2) k = -1;
      attempt(c, ($urandom_range(0, 4) == 0), 2'($urandom), k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
